sw_ctrl_frontend: RTL and testbench

- Input-side companion to the stopwatch core: turns raw pushbuttons into clean single-cycle events and runs the start/stop/lap/clear control FSM.
- Drives the core's `run`, `freeze` and `clear` controls.
- Sits between `ui_in` button pins and the time counter inside the top-level `tt_um_*` wrapper.
- Buttons are asynchronous and bouncy.
- All outputs are registered, in the `clk` domain.

---
 rtl/sw_ctrl_frontend_if.sv | 18 +
 rtl/sw_ctrl_frontend.sv | 80 ++++++++
 tb/tb_sw_ctrl_frontend.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sw_ctrl_frontend_if.sv
// sw_ctrl_frontend_if: raw pushbutton inputs and registered control/debug outputs of the stopwatch front end
interface sw_ctrl_frontend_if;
   logic       btn_start_raw;
   logic       btn_lap_raw;
   logic       run;
   logic       freeze;
   logic       clear;
   logic [1:0] state;
   logic [1:0] btn_level;
   modport master (
      output btn_start_raw, btn_lap_raw,
      input  run, freeze, clear, state, btn_level
   );
   modport slave (
      input  btn_start_raw, btn_lap_raw,
      output run, freeze, clear, state, btn_level
   );
endinterface

// File: rtl/sw_ctrl_frontend.sv
// sw_ctrl_frontend: button sync/debounce plus start/stop/lap/clear FSM; SW_LAP_EN enables the LAP (freeze) state
module sw_ctrl_frontend #(
   parameter int DEB_CYCLES = 16,
   parameter int CNT_W      = 5
) (
   input logic               clk,
   input logic               rst_n,
   sw_ctrl_frontend_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, STOPPED = 2'd2, LAP = 2'd3} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
   logic [1:0]       sync_q, s_q, level_q, level_d, prev_q, press;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   state_t           state_q, state_d;
   logic             run_q, run_d, freeze_q, freeze_d, clear_q, clear_d;
   // index 0 is the start button, index 1 the lap button
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i]   = (s_q[i] == level_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
         level_d[i] = (s_q[i] != level_q[i] && cnt_q[i] == CNT_MAX) ? s_q[i] : level_q[i];
      end
   end
   assign press = level_q & ~prev_q;
   // start is tested first everywhere so a simultaneous lap press is dropped
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      case (state_q)
         IDLE:    state_d = press[0] ? RUNNING : IDLE;
`ifdef SW_LAP_EN
         RUNNING: state_d = press[0] ? STOPPED : press[1] ? LAP : RUNNING;
         LAP:     state_d = press[0] ? STOPPED : press[1] ? RUNNING : LAP;
`else
         RUNNING: state_d = press[0] ? STOPPED : RUNNING;
`endif
         STOPPED: begin
            state_d = press[0] ? RUNNING : press[1] ? IDLE : STOPPED;
            clear_d = ~press[0] & press[1];
         end
         default: state_d = IDLE;
      endcase
      run_d = (state_d == RUNNING) || (state_d == LAP);
`ifdef SW_LAP_EN
      freeze_d = (state_d == LAP);
`else
      freeze_d = 1'b0;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         s_q      <= '0;
         level_q  <= '0;
         prev_q   <= '0;
         cnt_q    <= '{default: '0};
         state_q  <= IDLE;
         run_q    <= 1'b0;
         freeze_q <= 1'b0;
         clear_q  <= 1'b0;
      end else begin
         sync_q   <= {bus.btn_lap_raw, bus.btn_start_raw};
         s_q      <= sync_q;
         level_q  <= level_d;
         prev_q   <= level_q;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         run_q    <= run_d;
         freeze_q <= freeze_d;
         clear_q  <= clear_d;
      end
   end
   assign bus.run       = run_q;
   assign bus.freeze    = freeze_q;
   assign bus.clear     = clear_q;
   assign bus.state     = state_q;
   assign bus.btn_level = level_q;
endmodule

// File: tb/tb_sw_ctrl_frontend.sv
// tb_sw_ctrl_frontend: table vectors, corner sequences and random buttons checked against a behavioural model
module tb_sw_ctrl_frontend;
   localparam int DEB = 4;
   localparam int HOLD = DEB + 6;
`ifdef SW_LAP_EN
   localparam bit LAPEN = 1'b1;
`else
   localparam bit LAPEN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   run_entries = 0;
   logic [1:0] last_state = 2'd0;
   sw_ctrl_frontend_if bus ();
   sw_ctrl_frontend #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // model: raw -> 2-cycle delay -> level flips after DEB consecutive differing samples
   logic m_h1 [2], m_h2 [2], m_lvl [2], m_prev [2];
   int   m_run [2];
   int   m_state;
   logic m_clear;
   function automatic int fsm_next(int s, logic st, logic lp);
      if (st) return (s == 0 || s == 2) ? 1 : 2;
      if (lp) return s == 1 ? (LAPEN ? 3 : 1) : s == 3 ? 1 : s == 2 ? 0 : s;
      return s;
   endfunction
   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_run[b] = 0;
      end
      m_state = 0;
      m_clear = 0;
   endtask
   task automatic model_step(input logic st_raw, input logic lp_raw);
      logic ev_st, ev_lp;
      logic raw [2];
      if (!rst_n) return;
      raw[0] = st_raw;
      raw[1] = lp_raw;
      ev_st = m_lvl[0] & ~m_prev[0];
      ev_lp = m_lvl[1] & ~m_prev[1];
      m_clear = (m_state == 2) && !ev_st && ev_lp;
      m_state = fsm_next(m_state, ev_st, ev_lp);
      for (int b = 0; b < 2; b++) begin
         m_prev[b] = m_lvl[b];
         if (m_h2[b] == m_lvl[b]) m_run[b] = 0;
         else begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
               m_lvl[b] = m_h2[b];
               m_run[b] = 0;
            end
         end
         m_h2[b] = m_h1[b];
         m_h1[b] = raw[b];
      end
   endtask
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cyc(input logic st, input logic lp);
      bus.btn_start_raw = st;
      bus.btn_lap_raw   = lp;
      @(posedge clk);
      model_step(st, lp);
      @(negedge clk);
      chk("state", 8'(bus.state), 8'(m_state));
      chk("run", 8'(bus.run), 8'(m_state == 1 || m_state == 3));
      chk("freeze", 8'(bus.freeze), 8'(m_state == 3));
      chk("clear", 8'(bus.clear), 8'(m_clear));
      chk("btn_level", 8'(bus.btn_level), 8'({m_lvl[1], m_lvl[0]}));
      if (bus.state == 2'd1 && last_state != 2'd1) run_entries++;
      last_state = bus.state;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst_n = 1'b1;
   endtask
   task automatic press(input logic st, input logic lp, output int clears);
      clears = 0;
      for (int i = 0; i < HOLD; i++) begin
         cyc(st, lp);
         clears += int'(bus.clear);
      end
      for (int i = 0; i < HOLD; i++) begin
         cyc(1'b0, 1'b0);
         clears += int'(bus.clear);
      end
   endtask
   typedef struct {
      logic       st;
      logic       lp;
      logic [1:0] exp_state;
      logic       exp_run;
      logic       exp_freeze;
      int         exp_clears;
   } vec_t;
   vec_t tbl [8];
   initial begin
      int edges, entries0, clears;
      bus.btn_start_raw = 1'b0;
      bus.btn_lap_raw   = 1'b0;
      tbl[0] = '{1, 0, 2'd1, 1, 0, 0};
      tbl[1] = '{0, 1, LAPEN ? 2'd3 : 2'd1, 1, LAPEN, 0};
      tbl[2] = '{0, 1, 2'd1, 1, 0, 0};
      tbl[3] = '{1, 0, 2'd2, 0, 0, 0};
      tbl[4] = '{0, 1, 2'd0, 0, 0, 1};
      tbl[5] = '{1, 0, 2'd1, 1, 0, 0};
      tbl[6] = '{1, 1, 2'd2, 0, 0, 0};
      tbl[7] = '{1, 0, 2'd1, 1, 0, 0};
      model_reset();
      for (int i = 0; i < 5; i++) cyc(1'($urandom), 1'($urandom));
      chk("reset_outputs", {bus.run, bus.freeze, bus.clear, bus.state, bus.btn_level}, 8'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
      chk("after_release_state", 8'(bus.state), 8'd0);
      edges = 0;
      while (!bus.run && edges < 30) begin
         cyc(1'b1, 1'b0);
         edges++;
      end
      chk("start_latency_edges", 8'(edges), 8'd7);
      entries0 = run_entries;
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0);
      chk("held_no_repeat", 8'(run_entries - entries0), 8'd0);
      chk("held_state", 8'(bus.state), 8'd1);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
      do_reset();
      entries0 = run_entries;
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
      chk("bounce_one_entry", 8'(run_entries - entries0), 8'd1);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
      chk("short_pulse_state", 8'(bus.state), 8'd0);
      chk("short_pulse_level", 8'(bus.btn_level), 8'd0);
      do_reset();
      for (int v = 0; v < 8; v++) begin
         press(tbl[v].st, tbl[v].lp, clears);
         chk($sformatf("vec%0d_state", v), 8'(bus.state), 8'(tbl[v].exp_state));
         chk($sformatf("vec%0d_run", v), 8'(bus.run), 8'(tbl[v].exp_run));
         chk($sformatf("vec%0d_freeze", v), 8'(bus.freeze), 8'(tbl[v].exp_freeze));
         chk($sformatf("vec%0d_clears", v), 8'(clears), 8'(tbl[v].exp_clears));
      end
      press(1'b0, 1'b1, clears);
      chk("lap_in_running_state", 8'(bus.state), LAPEN ? 8'd3 : 8'd1);
      chk("lap_in_running_freeze", 8'(bus.freeze), 8'(LAPEN));
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_state", 8'(bus.state), 8'd0);
      chk("async_reset_freeze", 8'(bus.freeze), 8'd0);
      cyc(1'b0, 1'b0);
      rst_n = 1'b1;
      clears = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0);
         clears += int'(bus.clear);
      end
      chk("reset_no_clear", 8'(clears), 8'd0);
      do_reset();
      for (int seg = 0; seg < 300; seg++) begin
         logic st, lp;
         int len;
         st  = 1'($urandom);
         lp  = 1'($urandom);
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) cyc(st, lp);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
